fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the SIMD pipeline, and the consumer of the branch-resolution signal produced by execute. It owns the program counter and drives the synchronous instruction memory. It also owns the IF/ID pipeline register. When execute reports a taken branch, it redirects the PC, squashes wrong-path words and asserts `flush` toward the decode→execute register. A halt seen in decode freezes fetch until reset.

## Interface
Parameters:
- `addrSize`, 16: PC and instruction-memory address width (word addressed).
- `instrSize`, 32: instruction word width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pcWrEn` in 1: branch taken, driven by execute's `pcWrEnOut`.
- `branchTarget` in `addrSize`: redirect address, valid when `pcWrEn`=1.
- `stall` in 1: hazard hold from decode.
- `haltIn` in 1: decode has identified the instruction currently in IF/ID as HALT.
- `instrIn` in `instrSize`: instruction-memory read data. It is the word at the address presented one cycle earlier with `imemEn`=1, and it holds when `imemEn`=0.
- `imemAddr` out `addrSize`: read address; equals the PC register.
- `imemEn` out 1: memory read enable.
- `instrOut` out `instrSize`: IF/ID instruction.
- `pcOut` out `addrSize`: address of `instrOut`.
- `validOut` out 1: IF/ID holds a real instruction.
- `flush` out 1: squash decode→execute register this cycle.
- `halted` out 1: fetch frozen.

## Operation
- Registers:
  - `pc`: next address to request.
  - `fetchPc`: address of the word now on `instrIn`.
  - IF/ID: `instrOut`, `pcOut`, `validOut`.
  - State: FILL, RUN, HALT.
- FILL (no valid word on `instrIn`):
  - `imemEn`=1.
  - `fetchPc`<=`pc`, `pc`<=`pc`+1.
  - `validOut`<=0.
  - Next state RUN.
- RUN, `stall`=0:
  - `imemEn`=1.
  - IF/ID <= {`instrIn`, `fetchPc`, 1}.
  - `fetchPc`<=`pc`, `pc`<=`pc`+1.
- RUN, `stall`=1:
  - `imemEn`=0.
  - `pc`, `fetchPc` and IF/ID all hold.
- Redirect (`pcWrEn`=1 in FILL or RUN; highest priority, overrides `stall` and `haltIn`):
  - `flush`=1 combinationally in the same cycle.
  - `pc`<=`branchTarget`, `validOut`<=0.
  - Next state FILL, which discards the stale word returning on `instrIn`.
  - `imemEn`=1.
- Halt entry (RUN, `validOut`=1, `haltIn`=1, `pcWrEn`=0):
  - The HALT instruction is passed downstream this cycle.
  - `validOut`<=0, next state HALT; the word on `instrIn` is discarded.
- HALT:
  - `imemEn`=0, `validOut`=0, `halted`=1, `flush`=0.
  - All inputs except `rst` are ignored. Exit is by reset only.
- `flush` = `pcWrEn` & (state != HALT); it is never registered.
- PC arithmetic is modulo 2^`addrSize`: 0xFFFF+1 wraps to 0x0000 (16-bit). `branchTarget` is used unmodified.

## Timing
- Reset values:
  - Registers: `pc`=0, `fetchPc`=0, state=FILL.
  - Outputs: `instrOut`=0, `pcOut`=0, `validOut`=0, `halted`=0, `flush`=0 (with `pcWrEn`=0); `imemAddr`=0, `imemEn`=1 (follow the reset state).
- `rst` has priority over every other input, including a redirect in progress or HALT.
- After `rst` deasserts at edge E0:
  - Address 0 is requested in cycle 0.
  - The address-0 word is on `instrIn` in cycle 1 (FILL→RUN).
  - `instrOut` is valid with `pcOut`=0 from cycle 2.
- Branch penalty:
  - Redirect asserted in cycle t: `imemAddr`=target in cycle t+1.
  - `validOut`=0 in cycles t+1 and t+2.
  - Target instruction valid in IF/ID in cycle t+3.
- Stall has zero latency: `imemEn` drops in the same cycle, and IF/ID is unchanged at the following edge.
- Back-to-back redirects (t and t+1): the second target wins and FILL restarts. Exactly one FILL cycle follows the last redirect.
- `stall`=1 during FILL: FILL still advances. Stall only freezes RUN.

## Test plan
- Reset, then free-run with memory[i]=0x1000_0000+i:
  - `validOut` rises in cycle 2.
  - `pcOut` runs 0,1,2,3 in consecutive cycles, with matching `instrOut`.
- Hold `stall`=1 for 3 cycles while `pcOut`=5:
  - `imemEn`=0 for those cycles; `instrOut`/`pcOut` held at address 5.
  - `pcOut`=6 appears one cycle after `stall` drops, with no address skipped or duplicated.
- `pcWrEn`=1, `branchTarget`=0x0040 while `pcOut`=9:
  - `flush`=1 in that cycle only.
  - `validOut`=0 for the next 2 cycles.
  - Then `pcOut`=0x0040, 0x0041.
- `pcWrEn`=1 with `stall`=1 and `haltIn`=1 together:
  - Redirect taken, no halt, `flush`=1.
  - Target fetched as in the branch scenario.
- `haltIn`=1 with `pcOut`=0x0012 valid:
  - HALT passes downstream, then `validOut`=0 and `halted`=1 with `imemEn`=0.
  - A later `pcWrEn`=1 produces `flush`=0.
  - `rst` restarts fetch at address 0.
- Branch to 0xFFFE, free-run: `pcOut` runs 0xFFFE, 0xFFFF, 0x0000.
- Separately, assert `rst` in the FILL cycle after a redirect: all reset values are restored, with no residual `flush`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request and IF/ID register with branch redirect, stall and halt.
module fetch_stage #(
  parameter int addrSize  = 16,
  parameter int instrSize = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcWrEn,
  input  logic [addrSize-1:0]  branchTarget,
  input  logic                 stall,
  input  logic                 haltIn,
  input  logic [instrSize-1:0] instrIn,
  output logic [addrSize-1:0]  imemAddr,
  output logic                 imemEn,
  output logic [instrSize-1:0] instrOut,
  output logic [addrSize-1:0]  pcOut,
  output logic                 validOut,
  output logic                 flush,
  output logic                 halted
);
  typedef enum logic [1:0] {FILL, RUN, HALT} state_t;
  state_t               state_q, state_d;
  logic [addrSize-1:0]  pc_q, pc_d, fetch_pc_q, fetch_pc_d, pc_out_q, pc_out_d;
  logic [instrSize-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d, imem_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      pc_q       <= '0;
      fetch_pc_q <= '0;
      pc_out_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end
  // Priority: halted freeze, redirect, fill, halt entry, normal advance; stall just falls through as a hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    imem_en    = 1'b0;
    if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (pcWrEn) begin
      imem_en = 1'b1;
      pc_d    = branchTarget;
      valid_d = 1'b0;
      state_d = FILL;
    end else if (state_q == FILL) begin
      imem_en    = 1'b1;
      fetch_pc_d = pc_q;
      pc_d       = pc_q + 1'b1;
      valid_d    = 1'b0;
      state_d    = RUN;
    end else if (valid_q && haltIn) begin
      valid_d = 1'b0;
      state_d = HALT;
    end else if (!stall) begin
      imem_en    = 1'b1;
      instr_d    = instrIn;
      pc_out_d   = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = pc_q;
      pc_d       = pc_q + 1'b1;
    end
  end
  assign imemAddr = pc_q;
  assign imemEn   = imem_en;
  assign instrOut = instr_q;
  assign pcOut    = pc_out_q;
  assign validOut = valid_q;
  assign halted   = state_q == HALT;
  assign flush    = pcWrEn && state_q != HALT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a synchronous memory holding 0x1000_0000+addr.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, pcWrEn, stall, haltIn;
  logic [15:0] branchTarget, imemAddr, pcOut;
  logic [31:0] instrIn, instrOut;
  logic        imemEn, validOut, flush, halted;
  int          checks = 0;
  int          errors = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pcWrEn(pcWrEn), .branchTarget(branchTarget), .stall(stall),
    .haltIn(haltIn), .instrIn(instrIn), .imemAddr(imemAddr), .imemEn(imemEn),
    .instrOut(instrOut), .pcOut(pcOut), .validOut(validOut), .flush(flush), .halted(halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imemEn) instrIn <= 32'h1000_0000 + {16'h0, imemAddr};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic chk_valid(input string tag, input logic [15:0] a);
    chk({tag, " valid"}, {31'h0, validOut}, 32'h1);
    chk({tag, " pcOut"}, {16'h0, pcOut}, {16'h0, a});
    chk({tag, " instrOut"}, instrOut, 32'h1000_0000 + {16'h0, a});
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, {31'h0, validOut}, 32'h0);
    chk({tag, " pcOut"}, {16'h0, pcOut}, 32'h0);
    chk({tag, " instrOut"}, instrOut, 32'h0);
    chk({tag, " halted"}, {31'h0, halted}, 32'h0);
    chk({tag, " flush"}, {31'h0, flush}, 32'h0);
    chk({tag, " imemAddr"}, {16'h0, imemAddr}, 32'h0);
    chk({tag, " imemEn"}, {31'h0, imemEn}, 32'h1);
  endtask
  initial begin
    rst = 1'b1; pcWrEn = 1'b0; stall = 1'b0; haltIn = 1'b0; branchTarget = 16'h0;
    tick; tick;
    settle; chk_reset("reset");
    rst = 1'b0;
    settle;
    chk("c0 imemAddr", {16'h0, imemAddr}, 32'h0);
    chk("c0 imemEn", {31'h0, imemEn}, 32'h1);
    tick; settle;
    chk("c1 valid", {31'h0, validOut}, 32'h0);
    chk("c1 imemAddr", {16'h0, imemAddr}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick; settle; chk_valid("run", 16'(i));
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle; chk("stall imemEn", {31'h0, imemEn}, 32'h0);
      chk_valid("stall hold", 16'h5);
      tick;
    end
    stall = 1'b0;
    settle; chk_valid("unstall", 16'h5);
    chk("unstall imemEn", {31'h0, imemEn}, 32'h1);
    for (int i = 6; i < 10; i++) begin
      tick; settle; chk_valid("after stall", 16'(i));
    end
    pcWrEn = 1'b1; branchTarget = 16'h0040;
    settle; chk("br flush", {31'h0, flush}, 32'h1);
    tick; pcWrEn = 1'b0;
    settle; chk("br t1 flush", {31'h0, flush}, 32'h0);
    chk("br t1 valid", {31'h0, validOut}, 32'h0);
    chk("br t1 imemAddr", {16'h0, imemAddr}, 32'h40);
    tick; settle; chk("br t2 valid", {31'h0, validOut}, 32'h0);
    tick; settle; chk_valid("br t3", 16'h40);
    tick; settle; chk_valid("br t4", 16'h41);
    pcWrEn = 1'b1; stall = 1'b1; haltIn = 1'b1; branchTarget = 16'h0010;
    settle; chk("combo flush", {31'h0, flush}, 32'h1);
    chk("combo imemEn", {31'h0, imemEn}, 32'h1);
    tick; pcWrEn = 1'b0; stall = 1'b0; haltIn = 1'b0;
    settle; chk("combo t1 valid", {31'h0, validOut}, 32'h0);
    chk("combo t1 halted", {31'h0, halted}, 32'h0);
    tick; settle; chk("combo t2 valid", {31'h0, validOut}, 32'h0);
    for (int i = 16; i < 19; i++) begin
      tick; settle; chk_valid("combo run", 16'(i));
    end
    haltIn = 1'b1;
    settle; chk_valid("halt pass", 16'h12);
    tick; haltIn = 1'b0; pcWrEn = 1'b1; branchTarget = 16'h0099;
    settle; chk("halt valid", {31'h0, validOut}, 32'h0);
    chk("halt halted", {31'h0, halted}, 32'h1);
    chk("halt imemEn", {31'h0, imemEn}, 32'h0);
    chk("halt flush", {31'h0, flush}, 32'h0);
    tick; pcWrEn = 1'b0;
    settle; chk("halt hold", {31'h0, halted}, 32'h1);
    rst = 1'b1;
    tick; settle; chk_reset("halt reset");
    rst = 1'b0;
    tick; tick; settle; chk_valid("restart", 16'h0);
    pcWrEn = 1'b1; branchTarget = 16'hFFFE;
    tick; pcWrEn = 1'b0;
    tick; tick; settle; chk_valid("wrap a", 16'hFFFE);
    chk("wrap imemAddr", {16'h0, imemAddr}, 32'h0);
    tick; settle; chk_valid("wrap b", 16'hFFFF);
    tick; settle; chk_valid("wrap c", 16'h0000);
    pcWrEn = 1'b1; branchTarget = 16'h0020;
    tick; branchTarget = 16'h0030;
    settle; chk("b2b flush", {31'h0, flush}, 32'h1);
    tick; pcWrEn = 1'b0;
    settle; chk("b2b imemAddr", {16'h0, imemAddr}, 32'h30);
    tick; settle; chk("b2b valid", {31'h0, validOut}, 32'h0);
    tick; settle; chk_valid("b2b target", 16'h30);
    pcWrEn = 1'b1; branchTarget = 16'h0050;
    tick; pcWrEn = 1'b0; rst = 1'b1;
    tick; settle; chk_reset("fill reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
